// File: rtl/waveform_capture_pkg.sv
// Shared types and default sizing for the triggered waveform capture buffer.
package waveform_capture_pkg;

    localparam int DATA_W_DEF   = 14;
    localparam int DEPTH_DEF    = 1000;
    localparam int ADDR_W_DEF   = 10;
    localparam int PRE_TRIG_DEF = 100;

    typedef logic [DATA_W_DEF-1:0] sample_t;

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        ARMED,
        POST,
        DONE
    } state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one read port with a registered output.
module capture_ram #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 1000,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // No reset on the array or output register so the tools map this onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        q <= mem[raddr];
    end

endmodule

// File: rtl/waveform_capture.sv
// Triggered capture of one DEPTH-sample waveform, PRE_TRIG samples before the trigger edge,
// stored circularly in RAM and read back by logical index with 2-cycle latency.
//
// state    | meaning
// IDLE     | waiting for an arm rising edge
// PRE_FILL | collecting the first PRE_TRIG samples, triggers ignored
// ARMED    | writing continuously, waiting for a trigger rising edge
// POST     | writing the remaining post-trigger samples
// DONE     | buffer frozen and readable
module waveform_capture
    import waveform_capture_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PRE_TRIG = PRE_TRIG_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              trigger_in,
    input  logic              arm,
    input  logic [15:0]       rd_addr,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic [15:0]       wave_count,
    output logic              busy,
    output logic              done
);

    localparam int POST_LEN = DEPTH - PRE_TRIG;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fill_cnt;
    logic [ADDR_W-1:0] start_ptr;
    logic              arm_q;
    logic              trig_q;
    logic              arm_edge;
    logic              trig_edge;
    logic              we;
    logic [ADDR_W-1:0] wr_ptr_next;

    logic [16:0]       phys_sum;
    logic [16:0]       phys_wrap;
    logic [ADDR_W-1:0] raddr_q;
    logic              rd_ok_q;
    logic [DATA_W-1:0] ram_q;

    assign arm_edge  = arm & ~arm_q;
    assign trig_edge = trigger_in & ~trig_q;

    // Leaving PRE_FILL/ARMED on arm low aborts that same cycle, so no write then.
    assign we = reset_n && ((state == POST) ||
                            (((state == PRE_FILL) || (state == ARMED)) && arm));

    assign wr_ptr_next = (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            start_ptr  <= '0;
            wave_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            arm_q      <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            arm_q  <= arm;
            trig_q <= trigger_in;
            if (we) begin
                wr_ptr <= wr_ptr_next;
            end
            case (state)
                IDLE: begin
                    if (arm_edge) begin
                        state    <= PRE_FILL;
                        fill_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                PRE_FILL: begin
                    if (!arm) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (fill_cnt == ADDR_W'(PRE_TRIG - 1)) begin
                        state <= ARMED;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                ARMED: begin
                    if (!arm) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (trig_edge) begin
                        start_ptr <= (wr_ptr >= ADDR_W'(PRE_TRIG)) ?
                                     wr_ptr - ADDR_W'(PRE_TRIG) :
                                     wr_ptr + ADDR_W'(DEPTH - PRE_TRIG);
                        if (POST_LEN == 1) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            wave_count <= wave_count + 16'd1;
                        end else begin
                            state    <= POST;
                            fill_cnt <= ADDR_W'(1);
                        end
                    end
                end
                POST: begin
                    if (fill_cnt == ADDR_W'(POST_LEN - 1)) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        wave_count <= wave_count + 16'd1;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (arm_edge) begin
                        state    <= PRE_FILL;
                        fill_cnt <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Logical index -> physical RAM address, relative to the oldest pre-trigger sample.
    assign phys_sum  = 17'(start_ptr) + 17'(rd_addr);
    assign phys_wrap = (phys_sum >= 17'(DEPTH)) ? phys_sum - 17'(DEPTH) : phys_sum;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            raddr_q  <= '0;
            rd_ok_q  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            raddr_q  <= phys_wrap[ADDR_W-1:0];
            rd_ok_q  <= (state == DONE) && (rd_addr < 16'(DEPTH));
            rd_valid <= rd_ok_q;
        end
    end

    assign rd_data = rd_valid ? 16'(ram_q) : 16'd0;

    capture_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(wr_ptr),
        .wdata(sample_in),
        .raddr(raddr_q),
        .q    (ram_q)
    );

endmodule

// File: tb/tb_waveform_capture.sv
// Directed bench for waveform_capture (DEPTH=16, PRE_TRIG=4) with a readout scoreboard.
module tb_waveform_capture;

    localparam int DW = 14;
    localparam int DP = 16;
    localparam int PT = 4;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] sample_in;
    logic          trigger_in;
    logic          arm;
    logic [15:0]   rd_addr;
    logic [15:0]   rd_data;
    logic          rd_valid;
    logic [15:0]   wave_count;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        int          addr;
        logic [15:0] data;
        logic        valid;
    } sb_entry_t;

    sb_entry_t sb[$];

    waveform_capture #(
        .DATA_W  (DW),
        .DEPTH   (DP),
        .ADDR_W  (4),
        .PRE_TRIG(PT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_in (sample_in),
        .trigger_in(trigger_in),
        .arm       (arm),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wave_count(wave_count),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    assign sample_in = cyc[DW-1:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            sb_entry_t e;
            e = sb.pop_front();
            check($sformatf("rd_data[%0d]", e.addr), 32'(rd_data), 32'(e.data));
            check($sformatf("rd_valid[%0d]", e.addr), 32'(rd_valid), 32'(e.valid));
        end
    end

    // Issue n consecutive reads; expected sample for index i is exp_base+i when valid.
    task automatic read_seq(input int first, input int n, input int exp_base, input bit vld);
        sb_entry_t e;
        int guard;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rd_addr  = 16'(first + i);
            e.due    = cyc + 2;
            e.addr   = first + i;
            e.valid  = vld;
            e.data   = vld ? 16'((exp_base + i) & 32'h3fff) : 16'd0;
            sb.push_back(e);
        end
        guard = 0;
        while (sb.size() > 0 && guard < 6) begin
            @(negedge clk);
            guard++;
        end
        check("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_sample(input int v);
        int guard;
        guard = 0;
        while (32'(sample_in) != v && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("wait_sample", 32'(sample_in), 32'(v));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            trigger_in = 1'b0;
            n++;
        end while (!done && n < 40);
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic rearm();
        @(negedge clk);
        arm = 1'b0;
        @(negedge clk);
        arm = 1'b1;
    endtask

    initial begin
        int tv;
        int n;
        reset_n    = 1'b0;
        arm        = 1'b0;
        trigger_in = 1'b0;
        rd_addr    = 16'd0;

        // reset for 3 cycles
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_wave_count", 32'(wave_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("idle_hold_busy", 32'(busy), 32'd0);

        // basic capture around sample 100
        arm = 1'b1;
        @(negedge clk);
        check("prefill_busy", 32'(busy), 32'd1);
        wait_sample(100);
        trigger_in = 1'b1;
        tv = 32'(sample_in);
        wait_done(n);
        check("done_latency", 32'(n), 32'd12);
        check("busy_in_done", 32'(busy), 32'd0);
        check("wave_count_1", 32'(wave_count), 32'd1);
        read_seq(0, DP, tv - PT, 1'b1);
        read_seq(DP, 1, 0, 1'b0);
        read_seq(40000, 1, 0, 1'b0);

        // trigger during PRE_FILL is ignored
        rearm();
        @(negedge clk);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        trigger_in = 1'b1;
        @(negedge clk);
        trigger_in = 1'b0;
        repeat (6) @(negedge clk);
        check("t3_still_armed", 32'(done), 32'd0);
        trigger_in = 1'b1;
        tv = 32'(sample_in);
        wait_done(n);
        check("t3_latency", 32'(n), 32'd12);
        check("wave_count_2", 32'(wave_count), 32'd2);
        read_seq(0, DP, tv - PT, 1'b1);

        // long ARMED dwell so the write pointer wraps
        rearm();
        repeat (37) @(negedge clk);
        trigger_in = 1'b1;
        tv = 32'(sample_in);
        wait_done(n);
        check("wave_count_3", 32'(wave_count), 32'd3);
        read_seq(0, DP, tv - PT, 1'b1);

        // arm dropped in ARMED returns to IDLE
        rearm();
        repeat (8) @(negedge clk);
        arm = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_wave_count", 32'(wave_count), 32'd3);

        // reset in the middle of POST
        arm = 1'b1;
        repeat (8) @(negedge clk);
        trigger_in = 1'b1;
        @(negedge clk);
        trigger_in = 1'b0;
        repeat (3) @(negedge clk);
        check("post_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        arm     = 1'b0;
        @(negedge clk);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        check("midrst_wave_count", 32'(wave_count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("after_rst_idle", 32'(busy), 32'd0);
        arm = 1'b1;
        repeat (8) @(negedge clk);
        trigger_in = 1'b1;
        tv = 32'(sample_in);
        wait_done(n);
        check("wave_count_after_rst", 32'(wave_count), 32'd1);
        read_seq(0, DP, tv - PT, 1'b1);

        // out-of-range read, arm edge with simultaneous trigger
        read_seq(DP, 1, 0, 1'b0);
        @(negedge clk);
        arm = 1'b0;
        @(negedge clk);
        arm        = 1'b1;
        trigger_in = 1'b1;
        @(negedge clk);
        check("same_cycle_busy", 32'(busy), 32'd1);
        check("same_cycle_done", 32'(done), 32'd0);
        repeat (20) @(negedge clk);
        check("same_cycle_no_capture", 32'(done), 32'd0);
        read_seq(3, 1, 0, 1'b0);

        // wave_count wrap from 0xFFFF
        trigger_in = 1'b0;
        force dut.wave_count = 16'hFFFF;
        #1;
        release dut.wave_count;
        @(negedge clk);
        check("wave_count_preload", 32'(wave_count), 32'h0000FFFF);
        trigger_in = 1'b1;
        tv = 32'(sample_in);
        wait_done(n);
        check("wave_count_wrap", 32'(wave_count), 32'd0);
        read_seq(0, DP, tv - PT, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
